// File: rtl/vga_code_ctrl.sv
// vga_code_ctrl
//   Double-buffered display-code register for a VGA timing block. Two
//   requesters hand over new codes with a level req / pulse ack handshake.
//   An accepted code is held in a shadow register and only becomes visible
//   on `code` at the next rising edge of vsync, so the display never
//   changes mid-frame.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous reset, active HIGH despite the name
//   vsync      vertical sync from the timing block, active high
//   req0/code0 requester 0 request (level, held until ack0) and its code
//   req1/code1 requester 1 request (level, held until ack1) and its code
//   ack0/ack1  one-cycle pulse, cycle after the code entered the shadow
//   code       committed display code {left 12b, right 12b}, registered
//   pending    high while the shadow holds a code not yet committed
//   frame_cnt  number of vsync rising edges since reset, wraps
module vga_code_ctrl #(
    parameter logic [23:0] RESET_CODE = 24'h000000,
    parameter int          FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               req0,
    input  logic [23:0]        code0,
    input  logic               req1,
    input  logic [23:0]        code1,
    output logic               ack0,
    output logic               ack1,
    output logic [23:0]        code,
    output logic               pending,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        shadow_q, shadow_d;
    logic [23:0]        code_q, code_d;
    logic [1:0]         ack_q, ack_d;
    logic               lg_q, lg_d;
    logic               vsync_q;
    logic               pending_q, pending_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic [1:0]         req_vec;
    logic [1:0]         elig;
    logic               vs_edge;
    logic               grant_any;
    logic               gnt_idx;

    assign req_vec = {req1, req0};

    // A requester whose ack is on the wire this cycle still has req high
    // (it only drops it after seeing ack); mask it so it is not accepted
    // twice for the same handshake.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] & ~ack_q[gi];
        end
    endgenerate

    always_comb begin
        vs_edge   = vsync & ~vsync_q;
        grant_any = |elig;
        // Tie goes to the requester that was not granted last; otherwise
        // the single eligible one (index 1 only if requester 1 is eligible).
        gnt_idx   = (&elig) ? ~lg_q : elig[1];

        ack_d     = 2'b00;
        lg_d      = lg_q;
        shadow_d  = shadow_q;
        code_d    = code_q;
        state_d   = state_q;

        if (grant_any) begin
            ack_d    = gnt_idx ? 2'b10 : 2'b01;
            lg_d     = gnt_idx;
            shadow_d = gnt_idx ? code1 : code0;
        end

        // Commit reads the old shadow, so a grant in the same cycle is
        // queued behind it rather than skipping ahead.
        if (vs_edge && (state_q == ARMED)) begin
            code_d = shadow_q;
        end

        if (grant_any) begin
            state_d = ARMED;
        end else if (vs_edge && (state_q == ARMED)) begin
            state_d = IDLE;
        end

        pending_d = (state_d == ARMED);
        frame_d   = frame_q + {{(FRAME_W-1){1'b0}}, vs_edge};
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= 24'h000000;
            code_q    <= RESET_CODE;
            ack_q     <= 2'b00;
            lg_q      <= 1'b1;
            vsync_q   <= 1'b0;
            pending_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            code_q    <= code_d;
            ack_q     <= ack_d;
            lg_q      <= lg_d;
            vsync_q   <= vsync;
            pending_q <= pending_d;
            frame_q   <= frame_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign code      = code_q;
    assign pending   = pending_q;
    assign frame_cnt = frame_q;

endmodule
